// File: rtl/seq_frame_tx_if.sv
// seq_frame_tx_if: payload handshake between a parallel producer and seq_frame_tx.
interface seq_frame_tx_if #(parameter int DATA_W = 8) ();
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: shifts out PATTERN then the payload MSB first; define SEQ_TX_PARITY_EN for a trailing even-parity bit.
module seq_frame_tx #(
  parameter int               DATA_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1010),
  parameter int               GAP     = 0
) (
  input  logic          clk,
  input  logic          rst,
  seq_frame_tx_if.slave tx,
  output logic          dout,
  output logic          dout_en,
  output logic          busy,
  output logic          frame_done
);
`ifdef SEQ_TX_PARITY_EN
  localparam int FW = PAT_W + DATA_W + 1;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PAR, S_GAP} state_e;
`else
  localparam int FW = PAT_W + DATA_W;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_e;
`endif
  localparam logic [5:0] PAT_L = 6'(PAT_W - 1);
  localparam logic [5:0] DAT_L = 6'(DATA_W - 1);
  localparam logic [5:0] GAP_L = 6'(GAP - 1);
  state_e        state_q, state_d, tail;
  logic [5:0]    cnt_q, cnt_d;
  logic [FW-1:0] fr_q, fr_d, load;
  logic          en_d, done_d;
  assign tx.tx_ready = state_q == S_IDLE && !rst;
  assign tail = GAP > 0 ? S_GAP : S_IDLE;
  // The whole frame is loaded at handshake so one shifter serves sync, data and parity.
`ifdef SEQ_TX_PARITY_EN
  assign load   = {PATTERN, tx.tx_data, ^tx.tx_data};
  assign en_d   = state_d inside {S_SYNC, S_DATA, S_PAR};
  assign done_d = state_d == S_PAR;
`else
  assign load   = {PATTERN, tx.tx_data};
  assign en_d   = state_d inside {S_SYNC, S_DATA};
  assign done_d = state_d == S_DATA && cnt_d == DAT_L;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 6'd1;
    fr_d    = fr_q << 1;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        fr_d    = tx.tx_valid ? load : '0;
        state_d = tx.tx_valid ? S_SYNC : S_IDLE;
      end
      S_SYNC: if (cnt_q == PAT_L) begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: if (cnt_q == DAT_L) begin
`ifdef SEQ_TX_PARITY_EN
        state_d = S_PAR;
`else
        state_d = tail;
`endif
        cnt_d   = '0;
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        state_d = tail;
        cnt_d   = '0;
      end
`endif
      S_GAP: if (cnt_q == GAP_L) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // Outputs are registered from next-state so the first sync bit appears the cycle after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fr_q       <= '0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fr_q       <= fr_d;
      dout       <= en_d & fr_d[FW-1];
      dout_en    <= en_d;
      busy       <= state_d != S_IDLE;
      frame_done <= done_d;
    end
  end
endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter that produces the bitstream consumed by the team's Moore sequence detector. Accepts a parallel payload over a valid/ready handshake, then shifts out a fixed sync pattern (default 1010) followed by the payload, MSB first, one bit per clock. Sits between a parallel producer and the single-bit `din` line of the detector. A detector on the far end asserts its output after the final pattern bit.

## Interface
- `DATA_W`, 8: payload width in bits, 1..32.
- `PAT_W`, 4: sync pattern width in bits, 2..8.
- `PATTERN`, 4'b1010: sync pattern, sent MSB first.
- `GAP`, 0: extra idle cycles inserted after each frame, 0..15.

- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: reset rst, synchronous, active-high.
- `tx_valid` input 1: producer has a payload.
- `tx_data` input DATA_W: payload, sampled on handshake.
- `tx_ready` output 1: block can accept a payload.
- `dout` output 1: serial line, registered.
- `dout_en` output 1: high while `dout` carries a frame bit (pattern, data or parity).
- `busy` output 1: high from handshake until the frame and gap complete.
- `frame_done` output 1: single-cycle pulse coincident with the last frame bit.

## Operation
- States: IDLE, SYNC, DATA, PAR (present only with the macro), GAP.
- Reset: state IDLE, `dout`=0, `dout_en`=0, `busy`=0, `frame_done`=0, `tx_ready`=0 while `rst` is high. Counters and shift register are cleared.
- IDLE: `tx_ready`=1, `dout`=0. On `tx_valid && tx_ready`, load `tx_data` into the shift register, clear the bit counter and go to SYNC.
- SYNC: drives `PATTERN[PAT_W-1-cnt]`. After PAT_W bits, go to DATA.
- DATA: drives shift register MSB and shifts left each cycle. After DATA_W bits, go to PAR if enabled, otherwise to GAP (GAP>0) or IDLE (GAP=0).
- PAR: drives the parity bit for one cycle, then goes to GAP or IDLE under the same rule as DATA.
- GAP: `dout`=0, `dout_en`=0, `busy`=1. Stays for exactly GAP cycles, then goes to IDLE.
- Counter: 6-bit, compared against PAT_W-1 / DATA_W-1. Wrap never occurs because each state clears the counter on exit.
- Payload is captured on handshake. `tx_data` changes after acceptance do not affect the frame in flight.
- `tx_valid` while not ready is ignored, with no queuing. The producer must hold the payload.
- `rst` asserted mid-frame aborts at the next edge. The line returns to 0 with no partial tail, and the payload is discarded.

## Timing
- Handshake at edge k puts the first pattern bit on `dout` during cycle k+1. `dout_en`=1 and `busy`=1 from k+1.
- Frame length F = PAT_W + DATA_W (+1 with parity) cycles. The last bit is in cycle k+F, with `frame_done`=1 in that same cycle.
- IDLE is re-entered at cycle k+F+GAP+1, when `tx_ready` rises. The minimum spacing between frame starts is F+GAP+1 cycles, so there is always at least one 0 bit between frames.
- `tx_ready` is combinational from state only (IDLE && !rst). It never depends on `tx_valid`.
- `tx_ready` is 0 in the cycle `rst` is high, and 1 in the first cycle after `rst` deasserts.

## Configuration
- `SEQ_TX_PARITY_EN` defined: the PAR state exists and one even-parity bit follows the payload, so F = PAT_W + DATA_W + 1. The parity bit is the XOR of all `tx_data` bits captured at handshake.
- Not defined: there is no PAR state, F = PAT_W + DATA_W, and parity logic is absent.

## Test plan
- Reset: hold `rst` 3 cycles with `tx_valid`=1, `tx_data`=8'hA5. Required: `dout`=0, `dout_en`=0, `busy`=0, `tx_ready`=0 throughout, and no frame starts. `tx_ready`=1 in the first cycle after release.
- Single frame, defaults, macro off: send `tx_data`=8'hC3. Required: `dout` = 1,0,1,0,1,1,0,0,0,0,1,1 over 12 cycles with `dout_en`=1. `frame_done` pulses on the 12th bit, and `tx_ready` returns on cycle 13.
- Back-to-back with GAP=2: keep `tx_valid` high with 8'hFF then 8'h00. Required: exactly 3 zero cycles between frames (2 gap + 1 idle), and the second frame starts 15 cycles after the first.
- Parity, macro on: send 8'h07. Required: 13-bit frame ending in parity 1. Then send 8'h03, and the frame must end in parity 0.
- Abort: assert `rst` on the 6th bit of frame 8'h5A. Required: at the next edge `dout`=0, `dout_en`=0, `busy`=0, and no `frame_done`. A new frame sent after release is complete and correct.
- Loopback: connect `dout` to the detector's `din` and send 8'h00. Required: the detector output goes high exactly once, after the 4th bit (the last pattern bit).
